// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port memory arbiter. A datapath (CPU) port and a loader
//               (DMA) port compete for a single memory. One transaction is in
//               flight at a time; the winner's address/write-enable/write-data
//               are latched at grant and held on the memory bus until the
//               memory answers (mem_ready) or a wait-state timeout expires.
//
//               Optional feature macro: MEM_ARB_RR_EN
//                 defined   -> round-robin between simultaneous requests
//                 undefined -> fixed priority, CPU always wins
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata   CPU request port
//   dma_req/we/addr/wdata   DMA request port
//   cpu_gnt, dma_gnt        one-cycle pulse: request accepted
//   cpu_done, dma_done      one-cycle pulse: access complete
//   rdata, err              read data / timeout flag, valid in the done cycle
//   cpu_stall               combinational stall for the CPU control FSM
//   mem_req, mem_we         memory strobe / write enable
//   mem_addr, mem_wdata     memory address / write data
//   mem_rdata, mem_ready    memory read data / completion
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          cpu_gnt,
    output logic          dma_gnt,
    output logic          cpu_done,
    output logic          dma_done,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          cpu_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_C = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    // The abort fires in the BUSY cycle whose increment would make the wait
    // count reach TMO, so the done pulse lands exactly TMO cycles after grant.
    localparam logic [7:0] WAIT_LAST = 8'(TMO - 1);

    logic [1:0]    state;
    logic [7:0]    wait_cnt;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          win_cpu;
    logic          win_dma;
    logic          busy;

`ifdef MEM_ARB_RR_EN
    // 1 = DMA owned the most recent grant; reset value favours the CPU first.
    logic last_dma;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dma <= 1'b1;
        end else if (state == IDLE && (cpu_req || dma_req)) begin
            last_dma <= ~win_cpu;
        end
    end

    assign win_cpu = cpu_req & (~dma_req | last_dma);
`else
    assign win_cpu = cpu_req;
`endif
    assign win_dma = dma_req & ~win_cpu;

    assign busy = (state == BUSY_C) || (state == BUSY_D);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cpu_gnt  <= 1'b0;
            dma_gnt  <= 1'b0;
            cpu_done <= 1'b0;
            dma_done <= 1'b0;
            rdata    <= '0;
            err      <= 1'b0;
        end else begin
            cpu_gnt  <= 1'b0;
            dma_gnt  <= 1'b0;
            cpu_done <= 1'b0;
            dma_done <= 1'b0;
            case (state)
                IDLE: begin
                    // mem_ready is deliberately not looked at here.
                    if (win_cpu) begin
                        state    <= BUSY_C;
                        we_q     <= cpu_we;
                        addr_q   <= cpu_addr;
                        wdata_q  <= cpu_wdata;
                        wait_cnt <= 8'd0;
                        cpu_gnt  <= 1'b1;
                    end else if (win_dma) begin
                        state    <= BUSY_D;
                        we_q     <= dma_we;
                        addr_q   <= dma_addr;
                        wdata_q  <= dma_wdata;
                        wait_cnt <= 8'd0;
                        dma_gnt  <= 1'b1;
                    end
                end
                BUSY_C, BUSY_D: begin
                    // mem_ready wins over a coincident timeout.
                    if (mem_ready) begin
                        state    <= IDLE;
                        cpu_done <= (state == BUSY_C);
                        dma_done <= (state == BUSY_D);
                        rdata    <= we_q ? '0 : mem_rdata;
                        err      <= 1'b0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state    <= IDLE;
                        cpu_done <= (state == BUSY_C);
                        dma_done <= (state == BUSY_D);
                        rdata    <= '0;
                        err      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req   = busy;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Gated by rst_n so every output reads zero while reset is held.
    assign cpu_stall = rst_n & ~cpu_done &
                       ((cpu_req & (state == IDLE) & ~cpu_gnt) |
                        (state == BUSY_C) |
                        ((state == BUSY_D) & cpu_req));

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter. Stimulus pushes expected
//               grants and completions into queues; a monitor pops and
//               compares whenever the DUT pulses a grant or a done. A memory
//               responder answers after a programmable number of BUSY cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata;
    logic          cpu_gnt, dma_gnt, cpu_done, dma_done, err, cpu_stall;
    logic [DW-1:0] rdata;
    logic          mem_req, mem_we, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt), .cpu_done(cpu_done), .dma_done(dma_done),
        .rdata(rdata), .err(err), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    typedef struct { bit port; bit we; logic [31:0] addr; logic [31:0] wdata; } gnt_t;
    typedef struct { bit port; logic [31:0] rdata; bit err; int lat; } done_t;

    gnt_t        gq[$];
    done_t       dq[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_dones = 0;
    int          dones_seen = 0;
    bit          last_dma = 1'b1;     // model: 1 = DMA granted most recently
    int          rsp_delay = 1;       // BUSY cycle in which memory answers
    logic [31:0] rsp_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference arbitration: returns 1 when DMA wins.
    function automatic bit pick(input bit c, input bit d);
        bit w;
`ifdef MEM_ARB_RR_EN
        if (c && d) w = ~last_dma;
        else        w = ~c;
`else
        w = ~c;
`endif
        last_dma = w;
        return w;
    endfunction

    function automatic void expect_txn(input bit port, input bit we,
                                       input logic [31:0] a, input logic [31:0] wd);
        gnt_t  g;
        done_t d;
        g.port = port; g.we = we; g.addr = a; g.wdata = wd;
        gq.push_back(g);
        d.port  = port;
        d.err   = (rsp_delay > TMO);
        d.lat   = d.err ? TMO : rsp_delay;
        d.rdata = (d.err || we) ? 32'd0 : rsp_data;
        dq.push_back(d);
        exp_dones++;
    endfunction

    task automatic drive_port(input bit port, input bit we, input logic [31:0] a,
                              input logic [31:0] wd, input bit req);
        if (!port) begin
            cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = req;
        end else begin
            dma_we = we; dma_addr = a; dma_wdata = wd; dma_req = req;
        end
    endtask

    task automatic drop_req(input bit port);
        if (!port) cpu_req = 1'b0;
        else       dma_req = 1'b0;
    endtask

    task automatic wait_gnt(output bit who, output bit ok);
        ok  = 1'b0;
        who = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cpu_gnt || dma_gnt) begin
                who = dma_gnt;
                ok  = 1'b1;
                return;
            end
        end
        fail_now("grant_timeout");
    endtask

    task automatic wait_dones();
        for (int i = 0; i < 400; i++) begin
            if (dones_seen >= exp_dones) return;
            @(negedge clk);
        end
        fail_now("done_timeout");
        exp_dones = dones_seen;
    endtask

    task automatic single(input bit port, input bit we, input logic [31:0] a,
                          input logic [31:0] wd);
        bit who, ok;
        void'(pick(!port, port));
        expect_txn(port, we, a, wd);
        drive_port(port, we, a, wd, 1'b1);
        wait_gnt(who, ok);
        drop_req(port);
        wait_dones();
    endtask

    task automatic both(input bit cwe, input logic [31:0] ca, input logic [31:0] cwd,
                        input bit dwe, input logic [31:0] da, input logic [31:0] dwd);
        bit w1, w2, who, ok;
        w1 = pick(1'b1, 1'b1);
        if (w1) expect_txn(1'b1, dwe, da, dwd); else expect_txn(1'b0, cwe, ca, cwd);
        w2 = pick(w1, ~w1);
        if (w2) expect_txn(1'b1, dwe, da, dwd); else expect_txn(1'b0, cwe, ca, cwd);
        drive_port(1'b0, cwe, ca, cwd, 1'b1);
        drive_port(1'b1, dwe, da, dwd, 1'b1);
        wait_gnt(who, ok);
        drop_req(who);
        wait_gnt(who, ok);
        drop_req(who);
        cpu_req = 1'b0;
        dma_req = 1'b0;
        wait_dones();
    endtask

    // Memory responder: answers in BUSY cycle rsp_delay; random noise otherwise.
    initial begin
        int bc;
        bc = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                bc++;
                mem_ready = (bc == rsp_delay);
                mem_rdata = (bc == rsp_delay) ? rsp_data : $urandom;
            end else begin
                bc = 0;
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        bit    owner_valid;
        bit    owner;
        int    cnt;
        gnt_t  cur;
        done_t d;
        bit    exp_stall;
        owner_valid = 1'b0;
        owner = 1'b0;
        cnt = 0;
        cur = '{port: 1'b0, we: 1'b0, addr: 32'd0, wdata: 32'd0};
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                owner_valid = 1'b0;
                continue;
            end
            if (cpu_gnt && dma_gnt)   fail_now("double_grant");
            if (cpu_done && dma_done) fail_now("double_done");
            if (cpu_gnt || dma_gnt) begin
                if (gq.size() == 0) begin
                    fail_now("unexpected_grant");
                end else begin
                    cur = gq.pop_front();
                    chk("grant_port", 64'(dma_gnt), 64'(cur.port));
                    owner_valid = 1'b1;
                    owner = dma_gnt;
                    cnt = 0;
                end
            end else if (owner_valid) begin
                cnt++;
            end
            if (mem_req) begin
                if (!owner_valid) begin
                    fail_now("mem_req_without_grant");
                end else begin
                    chk("mem_addr",  64'(mem_addr),  64'(cur.addr));
                    chk("mem_we",    64'(mem_we),    64'(cur.we));
                    chk("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
                end
            end
            // CPU is stalled while its access is outstanding or while it is
            // asking without having been granted yet; never in its done cycle.
            exp_stall = !cpu_done && ((owner_valid && !owner) || cpu_req);
            chk("cpu_stall", 64'(cpu_stall), 64'(exp_stall));
            if (cpu_done || dma_done) begin
                dones_seen++;
                if (dq.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    d = dq.pop_front();
                    chk("done_port",    64'(dma_done), 64'(d.port));
                    chk("done_rdata",   64'(rdata),    64'(d.rdata));
                    chk("done_err",     64'(err),      64'(d.err));
                    chk("done_latency", 64'(cnt),      64'(d.lat));
                    chk("done_mem_req", 64'(mem_req),  64'd0);
                end
                owner_valid = 1'b0;
            end
        end
    end

    initial begin
        bit who, ok;
        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req",   64'(mem_req),   64'd0);
        chk("rst_gnt",       64'({cpu_gnt, dma_gnt}),  64'd0);
        chk("rst_done",      64'({cpu_done, dma_done}), 64'd0);
        chk("rst_rdata",     64'(rdata),     64'd0);
        chk("rst_err",       64'(err),       64'd0);
        chk("rst_mem_addr",  64'(mem_addr),  64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // CPU read, memory answers in the third BUSY cycle.
        rsp_delay = 3; rsp_data = 32'hDEADBEEF;
        single(1'b0, 1'b0, 32'h100, 32'h0);

        // DMA write, memory answers immediately.
        rsp_delay = 1; rsp_data = $urandom;
        single(1'b1, 1'b1, 32'h40, 32'h12345678);

        // Both requesters held across four grants.
        begin
            bit w;
            rsp_delay = 2; rsp_data = $urandom;
            for (int i = 0; i < 4; i++) begin
                w = pick(1'b1, 1'b1);
                if (w) expect_txn(1'b1, 1'b1, 32'h200, 32'hA5A5A5A5);
                else   expect_txn(1'b0, 1'b0, 32'h300, 32'h0);
            end
            drive_port(1'b0, 1'b0, 32'h300, 32'h0, 1'b1);
            drive_port(1'b1, 1'b1, 32'h200, 32'hA5A5A5A5, 1'b1);
            for (int i = 0; i < 4; i++) wait_gnt(who, ok);
            cpu_req = 1'b0;
            dma_req = 1'b0;
            wait_dones();
            repeat (3) @(negedge clk);
        end

        // Timeout and its boundaries (answer in the abort cycle wins).
        rsp_delay = 100; rsp_data = $urandom;
        single(1'b0, 1'b0, 32'h500, 32'h0);
        rsp_delay = TMO;     single(1'b1, 1'b0, 32'h504, 32'h0);
        rsp_delay = TMO - 1; single(1'b1, 1'b0, 32'h508, 32'h0);
        rsp_delay = TMO + 1; single(1'b0, 1'b1, 32'h50C, 32'h11);

        // CPU asks briefly while DMA is busy, then withdraws.
        rsp_delay = 6; rsp_data = $urandom;
        void'(pick(1'b0, 1'b1));
        expect_txn(1'b1, 1'b0, 32'h600, 32'h0);
        drive_port(1'b1, 1'b0, 32'h600, 32'h0, 1'b1);
        wait_gnt(who, ok);
        dma_req = 1'b0;
        @(negedge clk);
        drive_port(1'b0, 1'b1, 32'h700, 32'hCAFE, 1'b1);
        repeat (2) @(negedge clk);
        cpu_req = 1'b0;
        #2;
        chk("stall_after_cancel", 64'(cpu_stall), 64'd0);
        wait_dones();
        repeat (4) @(negedge clk);

        // Reset in the middle of a DMA access.
        rsp_delay = 100;
        void'(pick(1'b0, 1'b1));
        expect_txn(1'b1, 1'b1, 32'h800, 32'h77);
        drive_port(1'b1, 1'b1, 32'h800, 32'h77, 1'b1);
        wait_gnt(who, ok);
        dma_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_req",  64'(mem_req),  64'd0);
        chk("midrst_dma_done", 64'(dma_done), 64'd0);
        chk("midrst_err",      64'(err),      64'd0);
        dq.delete();
        exp_dones = dones_seen;
        last_dma = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rsp_delay = 2; rsp_data = $urandom;
        single(1'b0, 1'b0, 32'h900, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 24; i++) begin
            rsp_delay = int'($urandom_range(1, 20));
            rsp_data  = $urandom;
            if ($urandom_range(0, 2) == 0)
                both(1'($urandom), $urandom, $urandom, 1'($urandom), $urandom, $urandom);
            else
                single(1'($urandom), 1'($urandom), $urandom, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("grant_queue_empty", 64'(gq.size()), 64'd0);
        chk("done_queue_empty",  64'(dq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
